// File: rtl/move_input_conditioner_pkg.sv
// move_input_conditioner_pkg
// Shared constants for the move input conditioner:
//   N_CELLS  - board cells (one switch each)
//   IDX_W    - width of a binary cell index
//   state_t  - offer FSM states
//   PLAYER_X / PLAYER_O - encoding of the turn output
package move_input_conditioner_pkg;

  localparam int N_CELLS = 9;
  localparam int IDX_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

endpackage

// File: rtl/move_input_conditioner_input_debouncer.sv
// input_debouncer
// One switch channel: 2-flop synchronizer, counter debounce and a registered
// rising-edge pulse of the debounced level.
// Ports:
//   clk   - system clock
//   Reset - asynchronous active-low reset
//   raw   - raw asynchronous switch level
//   rise  - one-cycle pulse, high the cycle after the debounced level goes 0->1
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic Reset,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: the synchronized level must disagree with the accepted
  // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt  <= '0;
      rise <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p1;
      cnt    <= '0;
      rise   <= sync_p1;
    end else begin
      cnt  <= cnt + 1'b1;
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/move_input_conditioner.sv
// move_input_conditioner
// Turns nine raw cell switches into one-at-a-time move offers for the game
// logic, tracking used cells and whose turn it is.
// Ports:
//   clk          - system clock
//   Reset        - asynchronous active-low reset
//   sw_in        - raw cell switches, bit i = cell i
//   clear        - synchronous new-game clear (active-high)
//   winState     - game over; blocks and withdraws moves while high
//   move_ready   - downstream accepts the offered move
//   move_valid   - a move is offered
//   move_onehot  - one-hot cell of the offered move
//   move_idx     - binary index of the offered cell
//   turn         - player to move (PLAYER_X / PLAYER_O)
//   used         - cells accepted this game
module move_input_conditioner
  import move_input_conditioner_pkg::*;
#(
  parameter int N_IN            = N_CELLS,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [N_IN-1:0]   sw_in,
  input  logic              clear,
  input  logic              winState,
  input  logic              move_ready,
  output logic              move_valid,
  output logic [N_IN-1:0]   move_onehot,
  output logic [IDX_W-1:0]  move_idx,
  output logic              turn,
  output logic [N_IN-1:0]   used
);

  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  pending;
  logic [N_IN-1:0]  edge_ok;
  logic [N_IN-1:0]  req;
  logic [IDX_W-1:0] sel_idx;
  logic [N_IN-1:0]  sel_onehot;
  state_t           state;

  // Fixed priority: the lowest-numbered requesting cell wins.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_IN-1:0] v);
    logic [IDX_W-1:0] k;
    k = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) k = IDX_W'(i);
    end
    return k;
  endfunction

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .Reset (Reset),
      .raw   (sw_in[g]),
      .rise  (rise[g])
    );
  end

  // Edges on used cells are dropped. A fresh edge is arbitrated in the same
  // cycle it arrives so that it does not pay an extra cycle in pending.
  assign edge_ok    = rise & ~used;
  assign req        = pending | edge_ok;
  assign sel_idx    = lowest_idx(req);
  assign sel_onehot = N_IN'(1) << sel_idx;

  // Arbitration / offer stage
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      turn        <= PLAYER_X;
      used        <= '0;
      pending     <= '0;
    end else if (clear) begin
      state       <= ST_IDLE;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      turn        <= PLAYER_X;
      used        <= '0;
      pending     <= '0;
    end else if (winState) begin
      // Game over: drop queued edges and withdraw any live offer unaccepted.
      state       <= ST_IDLE;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      pending     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pending <= req;
          if (|req) begin
            state       <= ST_OFFER;
            move_valid  <= 1'b1;
            move_onehot <= sel_onehot;
            move_idx    <= sel_idx;
          end
        end
        ST_OFFER: begin
          if (move_ready) begin
            used        <= used | move_onehot;
            pending     <= req & ~move_onehot;
            turn        <= (turn == PLAYER_X) ? PLAYER_O : PLAYER_X;
            state       <= ST_IDLE;
            move_valid  <= 1'b0;
            move_onehot <= '0;
            move_idx    <= '0;
          end else begin
            pending <= req;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner
// Self-checking bench: a table of directed per-cycle vectors, hand-written
// multi-cycle sequences, and a randomized run compared each cycle against a
// behavioural model of the conditioner.
module tb_move_input_conditioner;

  localparam int N  = 9;
  localparam int DB = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic [N-1:0] sw_in = '0;
  logic         clear = 1'b0;
  logic         winState = 1'b0;
  logic         move_ready = 1'b0;
  logic         move_valid;
  logic [N-1:0] move_onehot;
  logic [3:0]   move_idx;
  logic         turn;
  logic [N-1:0] used;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  move_input_conditioner #(
    .N_IN            (N),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .sw_in       (sw_in),
    .clear       (clear),
    .winState    (winState),
    .move_ready  (move_ready),
    .move_valid  (move_valid),
    .move_onehot (move_onehot),
    .move_idx    (move_idx),
    .turn        (turn),
    .used        (used)
  );

  // ---------------- behavioural model ----------------
  // hist[j] holds the switch sample taken j edges ago. A channel's accepted
  // level flips once the four synchronized samples (2..5 edges old) all
  // disagree with it.
  logic [N-1:0] hist [0:5];
  logic [N-1:0] m_stable, m_rise, m_pend, m_used, m_cand, m_exp_oh;
  logic         m_valid, m_turn;
  int           m_k;
  bit           mchk_en = 0;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int j = 0; j < 6; j++) hist[j] = '0;
      m_stable = '0; m_rise = '0; m_pend = '0; m_used = '0;
      m_valid = 1'b0; m_turn = 1'b0; m_k = 0;
    end else begin
      if (clear) begin
        m_pend = '0; m_used = '0; m_turn = 1'b0; m_valid = 1'b0;
      end else if (winState) begin
        m_pend = '0; m_valid = 1'b0;
      end else begin
        m_cand = m_pend | (m_rise & ~m_used);
        if (m_valid) begin
          if (move_ready) begin
            m_used[m_k] = 1'b1;
            m_turn = !m_turn;
            m_valid = 1'b0;
            m_cand[m_k] = 1'b0;
          end
          m_pend = m_cand;
        end else begin
          m_pend = m_cand;
          for (int i = N - 1; i >= 0; i--) begin
            if (m_cand[i]) begin
              m_k = i;
              m_valid = 1'b1;
            end
          end
        end
      end
      for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = sw_in;
      m_rise = '0;
      for (int i = 0; i < N; i++) begin
        if (hist[2][i] != m_stable[i] && hist[3][i] != m_stable[i] &&
            hist[4][i] != m_stable[i] && hist[5][i] != m_stable[i]) begin
          m_stable[i] = hist[2][i];
          m_rise[i]   = hist[2][i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mchk_en && Reset) begin
      m_exp_oh = m_valid ? (N'(1) << m_k) : '0;
      n_chk++;
      if (move_valid !== m_valid || move_onehot !== m_exp_oh || turn !== m_turn ||
          used !== m_used || (m_valid && move_idx !== 4'(m_k))) begin
        n_fail++;
        $display("FAIL model t=%0t valid=%0b/%0b onehot=%h/%h idx=%0d/%0d turn=%0b/%0b used=%h/%h (actual/required)",
                 $time, move_valid, m_valid, move_onehot, m_exp_oh, move_idx, m_k,
                 turn, m_turn, used, m_used);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int c;
    c = 0;
    while (move_valid !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, move_valid, 1);
  endtask

  typedef struct {
    logic [N-1:0] sw;
    logic         rdy;
    logic         ev;
    logic [3:0]   eidx;
    logic [N-1:0] eused;
    logic         eturn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [N-1:0] sw, input logic rdy, input logic ev,
                              input logic [3:0] eidx, input logic [N-1:0] eused,
                              input logic eturn);
    vec_t v;
    v.sw = sw; v.rdy = rdy; v.ev = ev; v.eidx = eidx; v.eused = eused; v.eturn = eturn;
    vecs.push_back(v);
  endfunction

  initial begin
    // cell 4 rises: offer 2 sync + 4 debounce + 1 register edges later
    for (int i = 0; i < 6; i++) add(9'h010, 0, 0, 0, 9'h000, 0);
    add(9'h010, 0, 1, 4, 9'h000, 0);
    add(9'h010, 1, 0, 0, 9'h010, 1);
    add(9'h010, 0, 0, 0, 9'h010, 1);
    add(9'h010, 0, 0, 0, 9'h010, 1);
    // 3-cycle glitch on cell 2 is ignored
    for (int i = 0; i < 3; i++) add(9'h014, 0, 0, 0, 9'h010, 1);
    for (int i = 0; i < 6; i++) add(9'h010, 0, 0, 0, 9'h010, 1);
    // cell 2 held long enough is offered
    for (int i = 0; i < 6; i++) add(9'h014, 0, 0, 0, 9'h010, 1);
    add(9'h014, 0, 1, 2, 9'h010, 1);
    add(9'h014, 1, 0, 0, 9'h014, 0);
    add(9'h014, 0, 0, 0, 9'h014, 0);
    // re-toggling a used cell produces nothing
    for (int i = 0; i < 8; i++) add(9'h004, 0, 0, 0, 9'h014, 0);
    for (int i = 0; i < 8; i++) add(9'h014, 0, 0, 0, 9'h014, 0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("reset_valid", move_valid, 0);
    chk("reset_onehot", move_onehot, 0);
    chk("reset_idx", move_idx, 0);
    chk("reset_turn", turn, 0);
    chk("reset_used", used, 0);
    Reset = 1'b1;
    mchk_en = 1;

    // ---- table-driven vectors ----
    foreach (vecs[r]) begin
      sw_in = vecs[r].sw;
      move_ready = vecs[r].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", r), move_valid, vecs[r].ev);
      if (vecs[r].ev) begin
        chk($sformatf("vec%0d_idx", r), move_idx, vecs[r].eidx);
        chk($sformatf("vec%0d_onehot", r), move_onehot, 32'(N'(1) << vecs[r].eidx));
      end
      chk($sformatf("vec%0d_used", r), used, vecs[r].eused);
      chk($sformatf("vec%0d_turn", r), turn, vecs[r].eturn);
    end

    // ---- cells 1 and 7 debounce together, ready held ----
    sw_in = 9'h096;
    move_ready = 1'b1;
    wait_valid(20, "t3_first_valid");
    chk("t3_first_idx", move_idx, 1);
    @(negedge clk);
    chk("t3_hs1_valid", move_valid, 0);
    chk("t3_hs1_used", used, 9'h016);
    @(negedge clk);
    chk("t3_second_valid", move_valid, 1);
    chk("t3_second_idx", move_idx, 7);
    @(negedge clk);
    chk("t3_end_valid", move_valid, 0);
    chk("t3_end_turn", turn, 0);
    chk("t3_end_used", used, 9'h096);
    move_ready = 1'b0;

    // ---- winState withdraws a live offer ----
    sw_in = 9'h09E;
    wait_valid(20, "t5_valid");
    chk("t5_idx", move_idx, 3);
    @(negedge clk);
    chk("t5_hold_valid", move_valid, 1);
    chk("t5_hold_idx", move_idx, 3);
    winState = 1'b1;
    @(negedge clk);
    chk("t5_withdraw_valid", move_valid, 0);
    chk("t5_withdraw_used", used, 9'h096);
    chk("t5_withdraw_turn", turn, 0);
    sw_in = 9'h0BE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t5_blocked%0d", i), move_valid, 0);
    end
    winState = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t5_after%0d", i), move_valid, 0);
    end
    chk("t5_used_final", used, 9'h096);

    // ---- clear coinciding with a handshake ----
    Reset = 1'b0;
    sw_in = '0;
    repeat (2) @(negedge clk);
    chk("t6_reset_used", used, 0);
    Reset = 1'b1;
    sw_in = 9'h07F;
    move_ready = 1'b1;
    begin
      int c;
      c = 0;
      while (used !== 9'h07F && c < 60) begin
        @(negedge clk);
        c++;
      end
    end
    chk("t6_used7f", used, 9'h07F);
    chk("t6_turn_o", turn, 1);
    move_ready = 1'b0;
    sw_in = 9'h1FF;
    wait_valid(20, "t6_offer_valid");
    chk("t6_offer_idx", move_idx, 7);
    clear = 1'b1;
    move_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    move_ready = 1'b0;
    chk("t6_clear_valid", move_valid, 0);
    chk("t6_clear_used", used, 0);
    chk("t6_clear_turn", turn, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t6_noref%0d", i), move_valid, 0);
    end
    sw_in = 9'h1EF;
    repeat (8) @(negedge clk);
    sw_in = 9'h1FF;
    wait_valid(20, "t6_retoggle_valid");
    chk("t6_retoggle_idx", move_idx, 4);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    chk("t6_retoggle_used", used, 9'h010);
    chk("t6_retoggle_turn", turn, 1);

    // ---- randomized run against the model ----
    Reset = 1'b0;
    sw_in = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) sw_in[i] = ~sw_in[i];
      end
      move_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) winState = ~winState;
      clear = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    clear = 1'b0;
    winState = 1'b0;
    move_ready = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
